fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of decode and immediate generation. It holds the PC and issues word fetches to instruction memory over a valid/ready request channel. Responses land in a small in-order FIFO, which presents {inst, pc} to decode with a valid/ready handshake. Redirects from branches and jumps flush the FIFO and discard the responses of in-flight fetches.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction-memory request/response,
// redirect input and the decode-side handshake.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, credit-limited memory requests, in-order
// response FIFO toward decode, and redirect flush with response killing.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t        r_state, w_stateNext;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_inflight, r_count, r_kill;
    logic          r_boot;
    logic [31:0]   r_fifoInst [DEPTH];
    logic [31:0]   r_fifoPc   [DEPTH];
    logic [31:0]   r_pcq      [DEPTH];
    logic [AW-1:0] r_fifoHead, r_fifoTail, r_pcqHead, r_pcqTail;

    logic [CW:0]   w_credit;
    logic          w_reqFire, w_rsp, w_pop, w_push, w_drop, w_headValid;
    logic [CW-1:0] w_inflightNext, w_killNext;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Credit covers both in-flight and buffered fetches so a response always has a FIFO slot.
    assign w_credit           = {1'b0, r_inflight} + {1'b0, r_count};
    assign bus.imem_req_valid = !rst && !r_boot && !bus.redirect_valid &&
                                (w_credit < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = r_pc;
    assign w_reqFire          = bus.imem_req_valid && bus.imem_req_ready;
    assign w_rsp              = bus.imem_rsp_valid && !rst;

    assign w_headValid  = (r_count != '0);
    assign bus.id_valid = !rst && w_headValid;
    assign bus.id_inst  = bus.id_valid ? r_fifoInst[r_fifoHead] : NOP;
    assign bus.id_pc    = bus.id_valid ? r_fifoPc[r_fifoHead]   : 32'h0;
    assign w_pop        = bus.id_valid && bus.id_ready;

    always_comb begin
        w_inflightNext = r_inflight + CW'(w_reqFire) - CW'(w_rsp);
        w_drop         = w_rsp && ((r_state == DRAIN) || bus.redirect_valid);
        w_push         = w_rsp && !w_drop;
        w_killNext     = r_kill;
        w_stateNext    = r_state;
        // A redirect re-arms the kill count from whatever is still outstanding after this cycle.
        if (bus.redirect_valid) begin
            w_killNext  = w_inflightNext;
            w_stateNext = (w_inflightNext != '0) ? DRAIN : FETCH;
        end else begin
            case (r_state)
                FETCH: w_stateNext = FETCH;
                DRAIN: begin
                    if (w_rsp) begin
                        w_killNext = r_kill - CW'(1);
                        if (r_kill == CW'(1)) begin
                            w_stateNext = FETCH;
                        end
                    end
                end
                default: w_stateNext = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_kill  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_kill  <= w_killNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_count    <= '0;
            r_boot     <= 1'b1;
            r_fifoHead <= '0;
            r_fifoTail <= '0;
            r_pcqHead  <= '0;
            r_pcqTail  <= '0;
        end else begin
            r_boot     <= 1'b0;
            r_inflight <= w_inflightNext;
            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
            end else if (w_reqFire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_reqFire) begin
                r_pcqTail <= nextPtr(r_pcqTail);
            end
            // Killed responses still retire their PC queue entry to keep it aligned.
            if (w_rsp) begin
                r_pcqHead <= nextPtr(r_pcqHead);
            end
            if (bus.redirect_valid) begin
                r_fifoHead <= '0;
                r_fifoTail <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_fifoTail <= nextPtr(r_fifoTail);
                end
                if (w_pop) begin
                    r_fifoHead <= nextPtr(r_fifoHead);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_reqFire) begin
                r_pcq[r_pcqTail] <= r_pc;
            end
            if (w_push) begin
                r_fifoInst[r_fifoTail] <= bus.imem_rsp_data;
                r_fifoPc[r_fifoTail]   <= r_pcq[r_pcqHead];
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle tables for the listed corner cases, then
// random traffic against a transaction-level model of the fetched stream.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        reqReady;
        logic        rspValid;
        logic [31:0] rspData;
        logic        redirValid;
        logic [31:0] redirPc;
        logic        idReady;
        logic        expReqValid;
        logic [31:0] expAddr;
        logic        expIdValid;
        logic [31:0] expInst;
        logic [31:0] expPc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } memReq_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    function automatic vec_t mk(input logic r, input logic rr, input logic rv,
                                input logic [31:0] rd, input logic dv, input logic [31:0] dp,
                                input logic ir, input logic erv, input logic [31:0] ea,
                                input logic eiv, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = r;          v.reqReady = rr;    v.rspValid = rv;   v.rspData = rd;
        v.redirValid = dv;  v.redirPc = dp;     v.idReady = ir;
        v.expReqValid = erv; v.expAddr = ea;    v.expIdValid = eiv;
        v.expInst = ei;     v.expPc = ep;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst                = v.rst;
        bus.imem_req_ready = v.reqReady;
        bus.imem_rsp_valid = v.rspValid;
        bus.imem_rsp_data  = v.rspData;
        bus.redirect_valid = v.redirValid;
        bus.redirect_pc    = v.redirPc;
        bus.id_ready       = v.idReady;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkRow(input string tag, input vec_t v);
        checkOutput({tag, "_reqValid"}, 32'(bus.imem_req_valid), 32'(v.expReqValid));
        if (v.expReqValid) begin
            checkOutput({tag, "_reqAddr"}, bus.imem_req_addr, v.expAddr);
        end
        checkOutput({tag, "_idValid"}, 32'(bus.id_valid), 32'(v.expIdValid));
        checkOutput({tag, "_idInst"}, bus.id_inst, v.expInst);
        checkOutput({tag, "_idPc"}, bus.id_pc, v.expPc);
    endtask

    task automatic runSeq(input string tag, input vec_t q[$]);
        foreach (q[i]) begin
            applyStimulus(q[i]);
            checkRow($sformatf("%s%0d", tag, i), q[i]);
        end
    endtask

    initial begin
        vec_t        vecs[$];
        vec_t        seq[$];
        vec_t        v;
        memReq_t     memQ[$];
        memReq_t     e;
        int unsigned cyc;
        int unsigned lastDue;
        int unsigned due;
        logic [31:0] mPc, mDel, prevAddr, prevIdPc, prevIdInst;
        logic [31:0] redirTarget;
        bit          prevReqHold, prevIdHold, doRst, redir;
        int          delivered;

        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;

        // Sequential fetch, back-pressure from decode, held request, redirect with one in flight.
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0,NOP,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0,NOP,0));
        vecs.push_back(mk(0,1,0,0,0,0,1, 0,0,0,NOP,0));
        vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h0,0,NOP,0));
        vecs.push_back(mk(0,1,1,memWord(32'h0),0,0,1, 1,32'h4,0,NOP,0));
        vecs.push_back(mk(0,1,1,memWord(32'h4),0,0,1, 0,0,1,memWord(32'h0),32'h0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8,1,memWord(32'h4),32'h4));
        vecs.push_back(mk(0,1,1,memWord(32'h8),0,0,0, 0,0,1,memWord(32'h4),32'h4));
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,1,memWord(32'h4),32'h4));
        vecs.push_back(mk(0,1,0,0,0,0,1, 0,0,1,memWord(32'h4),32'h4));
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'hC,1,memWord(32'h8),32'h8));
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'hC,0,NOP,0));
        vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'hC,0,NOP,0));
        vecs.push_back(mk(0,1,0,0,1,32'h103,1, 0,0,0,NOP,0));
        vecs.push_back(mk(0,1,1,memWord(32'hC),0,0,1, 1,32'h100,0,NOP,0));
        vecs.push_back(mk(0,0,1,memWord(32'h100),0,0,1, 1,32'h104,0,NOP,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'h104,1,memWord(32'h100),32'h100));
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'h104,0,NOP,0));
        runSeq("vec", vecs);

        // Redirect to 0x103 with two fetches outstanding: both responses must vanish.
        seq.delete();
        seq.push_back(mk(1,0,0,0,0,0,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,0,0,0,0,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,0,0,0,0,0, 1,32'h0,0,NOP,0));
        seq.push_back(mk(0,1,0,0,0,0,0, 1,32'h4,0,NOP,0));
        seq.push_back(mk(0,1,0,0,1,32'h103,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,1,memWord(32'h0),0,0,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,1,memWord(32'h4),0,0,0, 1,32'h100,0,NOP,0));
        seq.push_back(mk(0,0,1,memWord(32'h100),0,0,0, 1,32'h104,0,NOP,0));
        seq.push_back(mk(0,0,0,0,0,0,0, 1,32'h104,1,memWord(32'h100),32'h100));
        runSeq("kill2_", seq);

        // Redirect coinciding with a response and a decode handshake.
        seq.delete();
        seq.push_back(mk(1,0,0,0,0,0,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,0,0,0,0,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,0,0,0,0,0, 1,32'h0,0,NOP,0));
        seq.push_back(mk(0,1,1,memWord(32'h0),0,0,0, 1,32'h4,0,NOP,0));
        seq.push_back(mk(0,1,1,memWord(32'h4),1,32'h200,1, 0,0,1,memWord(32'h0),32'h0));
        seq.push_back(mk(0,0,0,0,0,0,1, 1,32'h200,0,NOP,0));
        runSeq("redirHs", seq);

        // PC wrap at the top of memory, then reset in the middle of traffic.
        seq.delete();
        seq.push_back(mk(1,0,0,0,0,0,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,0,0,0,1,32'hFFFF_FFFE,0, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,0,0,0,0,0, 1,32'hFFFF_FFFC,0,NOP,0));
        seq.push_back(mk(0,0,0,0,0,0,0, 1,32'h0,0,NOP,0));
        seq.push_back(mk(1,1,1,memWord(32'hFFFF_FFFC),0,0,1, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,0,0,0,0,1, 0,0,0,NOP,0));
        seq.push_back(mk(0,1,0,0,0,0,1, 1,RESET_PC,0,NOP,0));
        runSeq("wrapRst", seq);

        // Random traffic: every delivered word must continue the PC stream started by the last redirect.
        applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,NOP,0));
        applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,NOP,0));
        memQ.delete();
        cyc = 0;
        lastDue = 0;
        mPc = RESET_PC;
        mDel = RESET_PC;
        prevReqHold = 0;
        prevIdHold = 0;
        prevAddr = 0;
        prevIdPc = 0;
        prevIdInst = 0;
        delivered = 0;
        for (int k = 0; k < 3000; k++) begin
            v = mk(0,0,0,$urandom,0,0,0, 0,0,0,NOP,0);
            doRst = ($urandom_range(0, 499) == 0);
            v.rst = doRst;
            if (doRst) begin
                memQ.delete();
                lastDue = 0;
            end else if (memQ.size() > 0 && memQ[0].due <= cyc) begin
                v.rspValid = 1'b1;
                v.rspData = memWord(memQ[0].addr);
                void'(memQ.pop_front());
            end
            redir = !doRst && ($urandom_range(0, 19) == 0);
            redirTarget = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom);
            v.redirValid = redir;
            v.redirPc = redirTarget;
            v.reqReady = ($urandom_range(0, 2) != 0);
            v.idReady = ($urandom_range(0, 3) != 0);
            applyStimulus(v);

            if (doRst) begin
                checkOutput("rand_rstReqValid", 32'(bus.imem_req_valid), 32'd0);
                checkOutput("rand_rstIdValid", 32'(bus.id_valid), 32'd0);
                mPc = RESET_PC;
                mDel = RESET_PC;
                prevReqHold = 0;
                prevIdHold = 0;
            end else begin
                if (redir) begin
                    checkOutput("rand_noReqOnRedirect", 32'(bus.imem_req_valid), 32'd0);
                end else if (prevReqHold) begin
                    checkOutput("rand_reqHeld", 32'(bus.imem_req_valid), 32'd1);
                    checkOutput("rand_addrHeld", bus.imem_req_addr, prevAddr);
                end
                if (prevIdHold) begin
                    checkOutput("rand_idHeld", 32'(bus.id_valid), 32'd1);
                    checkOutput("rand_idPcHeld", bus.id_pc, prevIdPc);
                    checkOutput("rand_idInstHeld", bus.id_inst, prevIdInst);
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    checkOutput("rand_fetchAddr", bus.imem_req_addr, mPc);
                    mPc = mPc + 32'd4;
                    due = cyc + $urandom_range(1, 3);
                    if (due <= lastDue) begin
                        due = lastDue + 1;
                    end
                    lastDue = due;
                    e.addr = bus.imem_req_addr;
                    e.due = due;
                    memQ.push_back(e);
                    checkOutput("rand_outstanding", 32'(memQ.size() <= DEPTH), 32'd1);
                end
                if (bus.id_valid && bus.id_ready) begin
                    checkOutput("rand_idPc", bus.id_pc, mDel);
                    checkOutput("rand_idInst", bus.id_inst, memWord(mDel));
                    mDel = mDel + 32'd4;
                    delivered++;
                end
                if (redir) begin
                    mPc = redirTarget & 32'hFFFF_FFFC;
                    mDel = redirTarget & 32'hFFFF_FFFC;
                end
                prevReqHold = bus.imem_req_valid && !bus.imem_req_ready && !redir;
                prevAddr = bus.imem_req_addr;
                prevIdHold = bus.id_valid && !bus.id_ready && !redir;
                prevIdPc = bus.id_pc;
                prevIdInst = bus.id_inst;
            end
            cyc++;
        end
        checkOutput("rand_progress", 32'(delivered > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
